// File: rtl/ysyx_2022040010_mem_arb_pkg.sv
// Shared encodings and sizing helpers for the IF/LS memory port arbiter.
package ysyx_2022040010_mem_arb_pkg;

    // FSM state encodings
    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_BUSY   = 1'b1;

    // Transaction owner encodings
    localparam logic [0:0] ARB_OWN_IF = 1'b0;
    localparam logic [0:0] ARB_OWN_LS = 1'b1;

    // Starvation counter width and its saturation value
    localparam int                   ARB_CNT_W   = 4;
    localparam logic [ARB_CNT_W-1:0] ARB_CNT_MAX = '1;

    // Width of the latched {we, wmask, wdata, addr} request bundle
    function automatic int arb_req_wd(input int addr_w, input int data_w);
        return 1 + (data_w / 8) + data_w + addr_w;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_arb_prio.sv
// Winner select between IF and LS plus the starvation counter.
// LS normally wins; IF wins once LS has been granted STARVE_MAX times in a
// row while IF kept requesting. The counter only moves while the arbiter is idle.
module ysyx_2022040010_arb_prio
    import ysyx_2022040010_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_i,
    input  logic if_req_i,
    input  logic ls_req_i,
    output logic win_if_o,
    output logic win_ls_o
);

    localparam logic [ARB_CNT_W-1:0] STARVE_LIM = ARB_CNT_W'(STARVE_MAX);

    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 starved;

    assign starved  = if_req_i && (cnt_q == STARVE_LIM);
    assign win_if_o = if_req_i && (!ls_req_i || starved);
    assign win_ls_o = ls_req_i && !win_if_o;

    // Next count: clear on IF grant or IF idle, saturating +1 on an LS grant that made IF wait
    always_comb begin
        cnt_d = cnt_q;
        if (idle_i) begin
            if (!if_req_i || win_if_o) begin
                cnt_d = '0;
            end else if (win_ls_o && (cnt_q != ARB_CNT_MAX)) begin
                cnt_d = cnt_q + ARB_CNT_W'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_2022040010_mem_arb.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// IDLE grants one requester and latches its fields; BUSY holds mem_req until
// mem_ack, then the owner gets a one-cycle rvalid with registered read data.
module ysyx_2022040010_mem_arb
    import ysyx_2022040010_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam int REQ_WD = arb_req_wd(ADDR_W, DATA_W);
    localparam int WD_LSB = ADDR_W;
    localparam int WM_LSB = ADDR_W + DATA_W;

    logic [0:0]        state_q, state_d;
    logic [0:0]        owner_q, owner_d;
    logic [REQ_WD-1:0] req_q, req_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic idle;
    logic win_if;
    logic win_ls;
    logic req_we;

    assign idle   = (state_q == ARB_IDLE);
    assign req_we = req_q[REQ_WD-1];

    ysyx_2022040010_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .idle_i   (idle),
        .if_req_i (if_req),
        .ls_req_i (ls_req),
        .win_if_o (win_if),
        .win_ls_o (win_ls)
    );

    // FSM next state, grant pulses, request latch and response capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = req_q;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_ls) begin
                    ls_gnt  = 1'b1;
                    owner_d = ARB_OWN_LS;
                    req_d   = {ls_we, ls_wmask, ls_wdata, ls_addr};
                    state_d = ARB_BUSY;
                end else if (win_if) begin
                    // Fetches are always plain reads with no byte mask
                    if_gnt  = 1'b1;
                    owner_d = ARB_OWN_IF;
                    req_d   = {1'b0, {MASK_W{1'b0}}, {DATA_W{1'b0}}, if_addr};
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    state_d = ARB_IDLE;
                    if (owner_q == ARB_OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = req_we ? {DATA_W{1'b0}} : mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, latched request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= ARB_OWN_IF;
            req_q       <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign mem_req   = (state_q == ARB_BUSY);
    assign mem_we    = req_we;
    assign mem_addr  = req_q[ADDR_W-1:0];
    assign mem_wdata = req_q[WD_LSB +: DATA_W];
    assign mem_wmask = req_q[WM_LSB +: MASK_W];

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_ysyx_2022040010_mem_arb.sv
// Self-checking bench for the IF/LS memory arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level reference model.
module tb_ysyx_2022040010_mem_arb;

    localparam int STARVE = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    ysyx_2022040010_mem_arb #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_wmask  (ls_wmask),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] hold_if;
    logic [63:0] hold_ls;

    typedef struct {
        logic        if_req;
        logic        ls_req;
        logic        ls_we;
        logic [63:0] if_addr;
        logic [63:0] ls_addr;
        logic [63:0] ls_wdata;
        logic [63:0] rdata;
        logic [63:0] exp_rdata;
        logic [7:0]  ls_wmask;
        int          wait_cyc;
        logic        exp_if;
        logic        exp_ls;
    } vec_t;

    vec_t vecs[6];

    // reference model state for the randomized run
    logic        m_busy, m_is_ls, m_we;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_mask;
    int          m_cnt;
    logic        m_if_rv, m_ls_rv;
    logic [63:0] m_if_rd, m_ls_rd;
    logic        if_pend, ls_pend;
    logic        e_if, e_ls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One table vector: grant from IDLE, wait_cyc idle memory cycles, ack, then response
    task automatic run_vec(input int idx, input vec_t v);
        logic        exp_we;
        logic [7:0]  exp_mask;
        logic [63:0] exp_addr;
        exp_we   = v.exp_ls ? v.ls_we : 1'b0;
        exp_mask = v.exp_ls ? v.ls_wmask : 8'h00;
        exp_addr = v.exp_ls ? v.ls_addr : v.if_addr;
        if_req   = v.if_req;
        if_addr  = v.if_addr;
        ls_req   = v.ls_req;
        ls_we    = v.ls_we;
        ls_addr  = v.ls_addr;
        ls_wdata = v.ls_wdata;
        ls_wmask = v.ls_wmask;
        mem_ack  = 1'b0;
        #3;
        chk("vec_if_gnt", if_gnt, v.exp_if);
        chk("vec_ls_gnt", ls_gnt, v.exp_ls);
        tick();
        if_req = 1'b0;
        ls_req = 1'b0;
        for (int w = 0; w <= v.wait_cyc; w++) begin
            mem_ack   = (w == v.wait_cyc);
            mem_rdata = mem_ack ? v.rdata : ~v.rdata;
            #3;
            chk("vec_mem_req", mem_req, 1'b1);
            chk("vec_mem_addr", mem_addr, exp_addr);
            chk("vec_mem_we", mem_we, exp_we);
            chk("vec_mem_wmask", mem_wmask, exp_mask);
            if (exp_we) chk("vec_mem_wdata", mem_wdata, v.ls_wdata);
            chk("vec_busy_if_rvalid", if_rvalid, 1'b0);
            chk("vec_busy_ls_rvalid", ls_rvalid, 1'b0);
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        #3;
        chk("vec_if_rvalid", if_rvalid, v.exp_if);
        chk("vec_ls_rvalid", ls_rvalid, v.exp_ls);
        chk("vec_mem_req_done", mem_req, 1'b0);
        chk("vec_if_rdata", if_rdata, v.exp_if ? v.exp_rdata : hold_if);
        chk("vec_ls_rdata", ls_rdata, v.exp_ls ? v.exp_rdata : hold_ls);
        if (v.exp_if) hold_if = v.exp_rdata;
        if (v.exp_ls) hold_ls = v.exp_rdata;
        $display("[TB] vec %0d owner=%s addr=%h rdata=%h", idx, v.exp_ls ? "LS" : "IF", exp_addr, v.exp_rdata);
        tick();
        #3;
        chk("vec_if_rvalid_drop", if_rvalid, 1'b0);
        chk("vec_ls_rvalid_drop", ls_rvalid, 1'b0);
        tick();
    endtask

    // Hold both requests with an instantly acking memory; record which grants went to IF
    task automatic run_both(input int n, output logic [15:0] bits);
        int got;
        got       = 0;
        bits      = '0;
        if_req    = 1'b1;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        mem_rdata = 64'h0;
        for (int c = 0; c < 8 * n && got < n; c++) begin
            #3;
            if (if_gnt) begin
                bits[got] = 1'b1;
                got++;
            end else if (ls_gnt) begin
                got++;
            end
            mem_ack = mem_req;
            tick();
        end
        if (got < n) chk("grant_budget", 64'(got), 64'(n));
    endtask

    task automatic drain();
        if_req = 1'b0;
        ls_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            mem_ack = mem_req;
            tick();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] order;

        rst = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
        ls_wdata = 0; ls_wmask = 0; mem_ack = 0; mem_rdata = 0;
        hold_if = 0; hold_ls = 0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h0,
                    64'h13, 64'h13, 8'h00, 1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 64'h8000_0010, 64'h8000_1000, 64'h0,
                    64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00, 0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h8000_2000, 64'hDEAD_BEEF,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F, 2, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h8000_0020, 64'h8000_2008, 64'h1234_5678_9ABC_DEF0,
                    64'h5555, 64'h0, 8'hFF, 0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 64'h8000_0004, 64'h0, 64'h0,
                    64'hA5A5_A5A5_5A5A_5A5A, 64'hA5A5_A5A5_5A5A_5A5A, 8'h00, 3, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h8000_3000, 64'h0,
                    64'hCAFE, 64'hCAFE, 8'h00, 1, 1'b0, 1'b1};

        // reset state
        tick(); tick();
        #3;
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_ls_gnt", ls_gnt, 1'b0);
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        chk("rst_ls_rvalid", ls_rvalid, 1'b0);
        chk("rst_if_rdata", if_rdata, 64'h0);
        chk("rst_ls_rdata", ls_rdata, 64'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_mem_wmask", mem_wmask, 8'h0);
        $display("[TB] reset state checked");
        tick();
        rst = 1'b0;

        // directed vector table
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // simultaneous requests: LS first, IF granted in the ls_rvalid cycle
        if_req = 1'b1; if_addr = 64'h8000_0040;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_1000; mem_ack = 1'b0;
        #3;
        chk("seq2_ls_gnt", ls_gnt, 1'b1);
        chk("seq2_if_gnt0", if_gnt, 1'b0);
        tick();
        ls_req = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h77;
        #3;
        chk("seq2_busy_if_gnt", if_gnt, 1'b0);
        chk("seq2_mem_addr_ls", mem_addr, 64'h8000_1000);
        tick();
        mem_ack = 1'b0;
        #3;
        chk("seq2_ls_rvalid", ls_rvalid, 1'b1);
        chk("seq2_ls_rdata", ls_rdata, 64'h77);
        chk("seq2_if_gnt_after", if_gnt, 1'b1);
        tick();
        if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h88;
        #3;
        chk("seq2_mem_addr_if", mem_addr, 64'h8000_0040);
        tick();
        mem_ack = 1'b0;
        #3;
        chk("seq2_if_rvalid", if_rvalid, 1'b1);
        chk("seq2_if_rdata", if_rdata, 64'h88);
        chk("seq2_ls_rdata_hold", ls_rdata, 64'h77);
        $display("[TB] seq LS-then-IF done");
        tick();

        // starvation: LS x4 then IF, repeating
        run_both(10, order);
        chk("starve_order", 64'(order[9:0]), 64'b10_0001_0000);
        $display("[TB] starvation grant order bits=%b", order[9:0]);
        drain();

        // reset while busy, counter at 3 LS grants
        run_both(3, order);
        chk("pre_rst_order", 64'(order[2:0]), 64'b000);
        if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
        #3;
        chk("pre_rst_mem_req", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h55;
        #3;
        chk("rst_busy_mem_req", mem_req, 1'b0);
        chk("rst_busy_if_rvalid", if_rvalid, 1'b0);
        chk("rst_busy_ls_rvalid", ls_rvalid, 1'b0);
        chk("rst_busy_mem_addr", mem_addr, 64'h0);
        tick();
        mem_ack = 1'b0;
        #3;
        chk("late_ack_if_rvalid", if_rvalid, 1'b0);
        chk("late_ack_ls_rvalid", ls_rvalid, 1'b0);
        chk("late_ack_mem_req", mem_req, 1'b0);
        chk("late_ack_ls_rdata", ls_rdata, 64'h0);
        tick();
        run_both(5, order);
        chk("post_rst_order", 64'(order[4:0]), 64'b10000);
        $display("[TB] reset mid-transaction done");
        drain();

        // mem_ack in IDLE with no requests is ignored
        mem_ack = 1'b1; mem_rdata = 64'hBAD;
        for (int c = 0; c < 2; c++) begin
            #3;
            chk("idle_ack_if_rvalid", if_rvalid, 1'b0);
            chk("idle_ack_ls_rvalid", ls_rvalid, 1'b0);
            chk("idle_ack_mem_req", mem_req, 1'b0);
            chk("idle_ack_if_rdata", if_rdata, 64'h0);
            chk("idle_ack_ls_rdata", ls_rdata, 64'h0);
            tick();
        end
        mem_ack = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_5000;
        #3;
        chk("idle_ack_still_idle", ls_gnt, 1'b1);
        $display("[TB] ack in IDLE ignored");
        drain();

        // randomized run against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_busy = 0; m_is_ls = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_mask = 0;
        m_cnt = 0; m_if_rv = 0; m_ls_rv = 0; m_if_rd = 0; m_ls_rd = 0;
        if_pend = 0; ls_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_pend) begin
                if_req  = ($urandom_range(3) != 0);
                if_addr = {$urandom, $urandom};
            end
            if (!ls_pend) begin
                ls_req   = ($urandom_range(3) != 0);
                ls_we    = 1'($urandom_range(1));
                ls_addr  = {$urandom, $urandom};
                ls_wdata = {$urandom, $urandom};
                ls_wmask = 8'($urandom);
            end
            if_pend   = if_req;
            ls_pend   = ls_req;
            mem_ack   = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            mem_rdata = {$urandom, $urandom};
            #3;
            e_if = 1'b0;
            e_ls = 1'b0;
            if (!m_busy) begin
                if (if_req && (!ls_req || m_cnt == STARVE)) e_if = 1'b1;
                else if (ls_req) e_ls = 1'b1;
            end
            chk("r_if_gnt", if_gnt, e_if);
            chk("r_ls_gnt", ls_gnt, e_ls);
            chk("r_mem_req", mem_req, m_busy);
            chk("r_if_rvalid", if_rvalid, m_if_rv);
            chk("r_ls_rvalid", ls_rvalid, m_ls_rv);
            chk("r_if_rdata", if_rdata, m_if_rd);
            chk("r_ls_rdata", ls_rdata, m_ls_rd);
            if (m_busy) begin
                chk("r_mem_addr", mem_addr, m_addr);
                chk("r_mem_we", mem_we, m_we);
                chk("r_mem_wmask", mem_wmask, m_mask);
                if (m_we) chk("r_mem_wdata", mem_wdata, m_wdata);
            end
            m_if_rv = 1'b0;
            m_ls_rv = 1'b0;
            if (m_busy) begin
                if (mem_ack) begin
                    m_busy = 1'b0;
                    if (m_is_ls) begin
                        m_ls_rv = 1'b1;
                        m_ls_rd = m_we ? 64'h0 : mem_rdata;
                    end else begin
                        m_if_rv = 1'b1;
                        m_if_rd = mem_rdata;
                    end
                end
            end else if (e_ls) begin
                m_busy = 1'b1; m_is_ls = 1'b1; m_we = ls_we; m_addr = ls_addr;
                m_wdata = ls_wdata; m_mask = ls_wmask;
                m_cnt = if_req ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
                ls_pend = 1'b0;
            end else if (e_if) begin
                m_busy = 1'b1; m_is_ls = 1'b0; m_we = 1'b0; m_addr = if_addr;
                m_wdata = 64'h0; m_mask = 8'h00; m_cnt = 0;
                if_pend = 1'b0;
            end else if (!if_req) begin
                m_cnt = 0;
            end
            tick();
        end
        $display("[TB] randomized run of 3000 cycles done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
